// File: rtl/ifetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
// The IFETCH_PERF_EN build option is handled in instruction_fetch.sv.
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;
    localparam int          DEF_DATA_W  = 32;
    localparam int          DEF_ADDR_W  = 32;

    typedef enum logic [1:0] {
        ACT_ISSUE,
        ACT_STALL,
        ACT_HOLD,
        ACT_REDIRECT
    } fetch_act_e;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ifetch_mem.sv
// Synchronous 1R1W instruction RAM; a read in the same cycle as a write
// to the same word returns the previous contents.
module ifetch_mem
    import ifetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clock,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC, output register and fault detection around ifetch_mem.
// Define IFETCH_PERF_EN to add the perf_fetches/perf_redirects counters.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DEPTH    = 256,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    localparam int                IDX_W    = idx_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fault,
    input  logic              load_en,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetches,
    output logic [31:0]       perf_redirects
`endif
);

    localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(DEPTH * INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              nop_q, nop_d;
    logic              hold, fault_now;
    logic [DATA_W-1:0] rd_data;
    fetch_act_e        act;

    assign hold      = valid_q & ~instr_ready;
    assign fault_now = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);

    always_comb begin
        act        = ACT_ISSUE;
        pc_d       = pc_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        nop_d      = nop_q;
        if (redirect_valid)  act = ACT_REDIRECT;
        else if (hold)       act = ACT_HOLD;
        else if (stall)      act = ACT_STALL;
        unique case (act)
            ACT_REDIRECT: begin
                pc_d    = redirect_pc;
                valid_d = 1'b0;
            end
            ACT_HOLD: ;
            ACT_STALL: valid_d = 1'b0;
            ACT_ISSUE: begin
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                fault_d    = fault_now;
                nop_d      = fault_now;
                pc_d       = pc_q + ADDR_W'(INSTR_BYTES);
            end
        endcase
    end

    // nop_q forces instr_out to zero after reset and on faulting issues,
    // since the RAM read register itself is neither reset nor loaded then.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            nop_q      <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            nop_q      <= nop_d;
        end
    end

    ifetch_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clock     (clock),
        .rd_en_i   ((act == ACT_ISSUE) & ~fault_now & ~reset),
        .rd_idx_i  (pc_q[IDX_W+1:2]),
        .rd_data_o (rd_data),
        .wr_en_i   (load_en),
        .wr_idx_i  (load_addr),
        .wr_data_i (load_data)
    );

    assign instr_valid = valid_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign instr_out   = nop_q ? DATA_W'(NOP_INSTR) : rd_data;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetches_q, perf_redirects_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetches_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (valid_q && instr_ready && perf_fetches_q != 32'hFFFF_FFFF) begin
                perf_fetches_q <= perf_fetches_q + 32'd1;
            end
            if (redirect_valid && perf_redirects_q != 32'hFFFF_FFFF) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_fetches   = perf_fetches_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (DEPTH=256, RESET_PC=0).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fault;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_redirects;
`endif

    int errors = 0;
    int checks = 0;

    instruction_fetch #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (256),
        .RESET_PC (32'h0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fault          (fault),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetches   (perf_fetches),
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Valid output: check pc, instruction and fault together.
    task automatic expect_out(input string tag, input logic [31:0] pc,
                              input logic [31:0] ins, input logic flt);
        check({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, ".pc"},    instr_pc, pc);
        check({tag, ".out"},   instr_out, ins);
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, flt});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

        load(8'd0, 32'd11);
        load(8'd1, 32'd22);
        load(8'd2, 32'd33);
        load(8'd3, 32'd44);
        load(8'd255, 32'h0000_ABCD);
        tick();
        expect_idle("rst");
        check("rst.out",   instr_out, 32'd0);
        check("rst.pc",    instr_pc, 32'd0);
        check("rst.fault", {31'b0, fault}, 32'd0);

        // Streaming fetch
        reset = 1'b0; instr_ready = 1'b1;
        tick(); expect_out("seq0", 32'd0, 32'd11, 1'b0);
        tick(); expect_out("seq1", 32'd4, 32'd22, 1'b0);

        // Backpressure hold for 3 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("hold", 32'd4, 32'd22, 1'b0);
        end
        instr_ready = 1'b1;
        tick(); expect_out("rel", 32'd8, 32'd33, 1'b0);
        tick(); expect_out("seq3", 32'd12, 32'd44, 1'b0);

        // Redirect to 4, then redirect away from a held output
        redirect_valid = 1'b1; redirect_pc = 32'd4;
        tick(); expect_idle("rd4.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("rd4", 32'd4, 32'd22, 1'b0);
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd12;
        tick(); expect_idle("rdh.gap");
        redirect_valid = 1'b0; instr_ready = 1'b1;
        tick(); expect_out("rdh", 32'd12, 32'd44, 1'b0);

        // Faults: misaligned, then first out-of-range, then recover
        redirect_valid = 1'b1; redirect_pc = 32'd6;
        tick(); expect_idle("f6.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("f6", 32'd6, 32'd0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'd1024;
        tick(); expect_idle("f1024.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("f1024", 32'd1024, 32'd0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick(); expect_idle("f0.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("f0", 32'd0, 32'd11, 1'b0);

        // Load colliding with the read of word 2 returns old data
        tick(); expect_out("col4", 32'd4, 32'd22, 1'b0);
        load_en = 1'b1; load_addr = 8'd2; load_data = 32'd99;
        tick(); expect_out("col8", 32'd8, 32'd33, 1'b0);
        load_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        tick(); expect_idle("new.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("new8", 32'd8, 32'd99, 1'b0);

        // Stall keeps pc
        stall = 1'b1;
        tick(); expect_idle("stall");
        stall = 1'b0;
        tick(); expect_out("unstall", 32'd12, 32'd44, 1'b0);

        // Last valid word, then the first out-of-range address after it
        redirect_valid = 1'b1; redirect_pc = 32'd1020;
        tick(); expect_idle("top.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("top", 32'd1020, 32'h0000_ABCD, 1'b0);
        tick(); expect_out("top+4", 32'd1024, 32'd0, 1'b1);

        // PC wrap modulo 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); expect_idle("wrap.gap");
        redirect_valid = 1'b0;
        tick(); expect_out("wrapF", 32'hFFFF_FFFC, 32'd0, 1'b1);
        tick(); expect_out("wrap0", 32'd0, 32'd11, 1'b0);

        // Reset while holding pc=12
        tick(); expect_out("pre4", 32'd4, 32'd22, 1'b0);
        tick(); expect_out("pre8", 32'd8, 32'd99, 1'b0);
        tick(); expect_out("pre12", 32'd12, 32'd44, 1'b0);
        instr_ready = 1'b0;
        tick(); expect_out("held12", 32'd12, 32'd44, 1'b0);
        reset = 1'b1;
        tick();
        expect_idle("mrst");
        check("mrst.fault", {31'b0, fault}, 32'd0);
        check("mrst.out",   instr_out, 32'd0);
        reset = 1'b0; instr_ready = 1'b1;
        tick(); expect_out("post0", 32'd0, 32'd11, 1'b0);
        tick(); expect_out("post4", 32'd4, 32'd22, 1'b0);
        tick(); expect_out("post8", 32'd8, 32'd99, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
